// File: rtl/frame_phase_scheduler.sv
// frame_phase_scheduler
//
// Sequences one image frame through three phases that share a single
// dual-port SRAM:
//   LOAD   - pixels arriving from SPI are written to SRAM port A at
//            consecutive addresses 0..IMAGE_SIZE-1.
//   DITHER - the dithering engine owns both SRAM ports; its requests are
//            forwarded combinationally. A one-cycle eng_start pulse
//            opens the phase and eng_done closes it.
//   STREAM - pixels are read back over port B one at a time and handed to
//            the MCU with a valid/ack handshake (mcu_rx_rdy/stream_ack).
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   mcu_tx_rdy                frame start request (honoured in IDLE only)
//   spi_valid, spi_byte       incoming pixel stream
//   eng_start, eng_done       dithering engine handshake
//   eng_addr_a/_b, eng_data_a, eng_wren_a, eng_rden_b
//                             engine SRAM requests (honoured in DITHER only)
//   sram_addr_a/_b, sram_data_a, sram_wren_a, sram_rden_b
//                             arbitrated SRAM drive
//   sram_q_b                  SRAM port B read data (one-cycle latency)
//   mcu_rx_rdy, stream_data, stream_ack
//                             outgoing pixel handshake
//   busy, frame_done, overrun status: not idle / end-of-frame pulse /
//                             sticky "spi_valid outside LOAD" flag
module frame_phase_scheduler #(
  parameter int IMAGEX     = 64,
  parameter int IMAGEY     = 64,
  parameter int IMAGE_SIZE = IMAGEX * IMAGEY,
  parameter int RGB_SIZE   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mcu_tx_rdy,
  input  logic                spi_valid,
  input  logic [RGB_SIZE-1:0] spi_byte,
  output logic                eng_start,
  input  logic                eng_done,
  input  logic [15:0]         eng_addr_a,
  input  logic [15:0]         eng_addr_b,
  input  logic [RGB_SIZE-1:0] eng_data_a,
  input  logic                eng_wren_a,
  input  logic                eng_rden_b,
  output logic [15:0]         sram_addr_a,
  output logic [15:0]         sram_addr_b,
  output logic [RGB_SIZE-1:0] sram_data_a,
  output logic                sram_wren_a,
  output logic                sram_rden_b,
  input  logic [RGB_SIZE-1:0] sram_q_b,
  output logic                mcu_rx_rdy,
  output logic [RGB_SIZE-1:0] stream_data,
  input  logic                stream_ack,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  localparam int               CNT_W    = $clog2(IMAGE_SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(IMAGE_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DITHER,
    S_STREAM_RD,
    S_STREAM_CAP,
    S_STREAM_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic [RGB_SIZE-1:0] stream_data_q, stream_data_d;
  logic                overrun_q, overrun_d;
  logic                eng_start_q, eng_start_d;
  logic                frame_done_q, frame_done_d;

  // State register: reset reaches every flop so that the block is quiet
  // immediately, even in the middle of a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pix_cnt_q     <= '0;
      stream_data_q <= '0;
      overrun_q     <= 1'b0;
      eng_start_q   <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      stream_data_q <= stream_data_d;
      overrun_q     <= overrun_d;
      eng_start_q   <= eng_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Next-state and SRAM arbitration
  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    stream_data_d = stream_data_q;
    overrun_d     = overrun_q;
    eng_start_d   = 1'b0;
    frame_done_d  = 1'b0;
    sram_addr_a   = '0;
    sram_addr_b   = '0;
    sram_data_a   = '0;
    sram_wren_a   = 1'b0;
    sram_rden_b   = 1'b0;
    mcu_rx_rdy    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mcu_tx_rdy) begin
          state_d   = S_LOAD;
          pix_cnt_d = '0;
          overrun_d = 1'b0;
        end
      end

      S_LOAD: begin
        if (spi_valid) begin
          sram_addr_a = 16'(pix_cnt_q);
          sram_data_a = spi_byte;
          sram_wren_a = 1'b1;
          if (pix_cnt_q == LAST_PIX) begin
            state_d     = S_DITHER;
            pix_cnt_d   = '0;
            // Registered so the pulse lands in the first DITHER cycle.
            eng_start_d = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + CNT_ONE;
          end
        end
      end

      S_DITHER: begin
        sram_addr_a = eng_addr_a;
        sram_addr_b = eng_addr_b;
        sram_data_a = eng_data_a;
        sram_wren_a = eng_wren_a;
        sram_rden_b = eng_rden_b;
        if (eng_done) begin
          state_d = S_STREAM_RD;
        end
      end

      S_STREAM_RD: begin
        sram_addr_b = 16'(pix_cnt_q);
        sram_rden_b = 1'b1;
        state_d     = S_STREAM_CAP;
      end

      S_STREAM_CAP: begin
        // SRAM read data is valid now, one cycle after the read strobe.
        stream_data_d = sram_q_b;
        state_d       = S_STREAM_HOLD;
      end

      S_STREAM_HOLD: begin
        mcu_rx_rdy = 1'b1;
        if (stream_ack) begin
          if (pix_cnt_q == LAST_PIX) begin
            state_d      = S_IDLE;
            pix_cnt_d    = '0;
            frame_done_d = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + CNT_ONE;
            state_d   = S_STREAM_RD;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A pixel offered outside LOAD is dropped (never written) and flagged.
    // This also wins over the clear on a frame start in the same cycle.
    if (spi_valid && (state_q != S_LOAD)) begin
      overrun_d = 1'b1;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign eng_start   = eng_start_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign stream_data = stream_data_q;

endmodule

// File: tb/tb_frame_phase_scheduler.sv
module tb_frame_phase_scheduler;

  localparam int N = 16;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        last;
  } wr_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mcu_tx_rdy = 1'b0;
  logic        spi_valid = 1'b0;
  logic [7:0]  spi_byte = '0;
  logic        eng_start;
  logic        eng_done = 1'b0;
  logic [15:0] eng_addr_a = '0;
  logic [15:0] eng_addr_b = '0;
  logic [7:0]  eng_data_a = '0;
  logic        eng_wren_a = 1'b0;
  logic        eng_rden_b = 1'b0;
  logic [15:0] sram_addr_a, sram_addr_b;
  logic [7:0]  sram_data_a;
  logic        sram_wren_a, sram_rden_b;
  logic [7:0]  sram_q_b = '0;
  logic        mcu_rx_rdy;
  logic [7:0]  stream_data;
  logic        stream_ack = 1'b0;
  logic        busy, frame_done, overrun;

  frame_phase_scheduler #(
    .IMAGEX(4), .IMAGEY(4), .IMAGE_SIZE(16), .RGB_SIZE(8)
  ) dut (
    .clk(clk), .rst(rst), .mcu_tx_rdy(mcu_tx_rdy),
    .spi_valid(spi_valid), .spi_byte(spi_byte),
    .eng_start(eng_start), .eng_done(eng_done),
    .eng_addr_a(eng_addr_a), .eng_addr_b(eng_addr_b),
    .eng_data_a(eng_data_a), .eng_wren_a(eng_wren_a), .eng_rden_b(eng_rden_b),
    .sram_addr_a(sram_addr_a), .sram_addr_b(sram_addr_b),
    .sram_data_a(sram_data_a), .sram_wren_a(sram_wren_a), .sram_rden_b(sram_rden_b),
    .sram_q_b(sram_q_b), .mcu_rx_rdy(mcu_rx_rdy), .stream_data(stream_data),
    .stream_ack(stream_ack), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // SRAM behaviour seen by the DUT
  logic [7:0] mem [N];
  always @(posedge clk) begin
    if (sram_wren_a) mem[sram_addr_a[3:0]] <= sram_data_a;
    if (sram_rden_b) sram_q_b <= mem[sram_addr_b[3:0]];
  end

  // Reference frame image: what the SRAM must hold according to the
  // sequence of loads and engine writes issued by the stimulus.
  logic [7:0] ref_mem [N];
  wr_t wr_q[$];
  rd_t rd_q[$];

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  bit frame_finished = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: pops expected transactions whenever the DUT presents one.
  bit          es_pending = 1'b0, fd_pending = 1'b0, rdy_prev = 1'b0;
  bit          rden_h1 = 1'b0, rden_h2 = 1'b0;
  logic [15:0] addr_h1 = '0, addr_h2 = '0;

  always @(negedge clk) begin
    wr_t e;
    rd_t r;
    bit  es_next, fd_next;
    es_next = 1'b0;
    fd_next = 1'b0;

    if (sram_wren_a) begin
      if (wr_q.size() == 0) begin
        fail("unexpected_write", 32'(sram_addr_a), 32'hFFFF_FFFF);
      end else begin
        e = wr_q.pop_front();
        chk("wr_addr", 32'(sram_addr_a), 32'(e.addr));
        chk("wr_data", 32'(sram_data_a), 32'(e.data));
        es_next = e.last;
      end
    end

    if (eng_start || es_pending) chk("eng_start", 32'(eng_start), 32'(es_pending));

    if (frame_done || fd_pending) begin
      chk("frame_done", 32'(frame_done), 32'(fd_pending));
      if (fd_pending) begin
        chk("idle_after_frame", 32'(busy), 32'd0);
        frame_finished = 1'b1;
      end
    end

    if (mcu_rx_rdy && !rdy_prev) begin
      chk("rd_latency_rden", 32'(rden_h2), 32'd1);
      chk("rd_latency_cap", 32'(rden_h1), 32'd0);
      if (rd_q.size() == 0) fail("unexpected_stream", 32'(addr_h2), 32'hFFFF_FFFF);
      else chk("rd_addr", 32'(addr_h2), 32'(rd_q[0].addr));
    end

    if (mcu_rx_rdy && stream_ack) begin
      if (rd_q.size() == 0) begin
        fail("unexpected_accept", 32'(stream_data), 32'hFFFF_FFFF);
      end else begin
        r = rd_q.pop_front();
        chk("stream_data", 32'(stream_data), 32'(r.data));
        acc_cnt++;
        if (rd_q.size() == 0) fd_next = 1'b1;
      end
    end

    es_pending = es_next;
    fd_pending = fd_next;
    rden_h2    = rden_h1;
    rden_h1    = sram_rden_b;
    addr_h2    = addr_h1;
    addr_h1    = sram_addr_b;
    rdy_prev   = mcu_rx_rdy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input bit gaps, input bit seq);
    int         i;
    int         cyc;
    logic [7:0] b;
    i = 0;
    cyc = 0;
    acc_cnt = 0;
    frame_finished = 1'b0;
    mcu_tx_rdy = 1'b1;
    tick();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_overrun_clear", 32'(overrun), 32'd0);
    while (i < N && cyc < 200) begin
      b = seq ? 8'(i) : 8'($urandom);
      mcu_tx_rdy = 1'($urandom_range(0, 1));
      eng_done   = 1'($urandom_range(0, 1));
      stream_ack = 1'($urandom_range(0, 1));
      if (gaps && $urandom_range(0, 2) == 0) begin
        spi_valid = 1'b0;
        #1;
        chk("gap_no_write", 32'(sram_wren_a), 32'd0);
      end else begin
        spi_valid = 1'b1;
        spi_byte  = b;
        ref_mem[i] = b;
        wr_q.push_back('{addr: 16'(i), data: b, last: (i == N - 1)});
        i++;
      end
      tick();
      cyc++;
    end
    if (i < N) fail("load_timeout", 32'(i), 32'(N));
    spi_valid = 1'b0;
    mcu_tx_rdy = 1'b0;
    eng_done = 1'b0;
    stream_ack = 1'b0;
    chk("dither_busy", 32'(busy), 32'd1);
  endtask

  task automatic do_dither(input bit eng_wr, input bit ovr);
    int len;
    len = $urandom_range(4, 8);
    for (int k = 0; k < len; k++) begin
      stream_ack = 1'($urandom_range(0, 1));
      mcu_tx_rdy = 1'($urandom_range(0, 1));
      spi_valid  = ovr && (k == 2);
      if (eng_wr && k == 1) begin
        eng_wren_a = 1'b1;
        eng_addr_a = 16'd5;
        eng_data_a = 8'hFF;
        eng_rden_b = 1'b1;
        eng_addr_b = 16'd9;
        ref_mem[5] = 8'hFF;
        wr_q.push_back('{addr: 16'd5, data: 8'hFF, last: 1'b0});
        #1;
        chk("pt_wren", 32'(sram_wren_a), 32'd1);
        chk("pt_addr_a", 32'(sram_addr_a), 32'd5);
        chk("pt_data_a", 32'(sram_data_a), 32'hFF);
        chk("pt_rden", 32'(sram_rden_b), 32'd1);
        chk("pt_addr_b", 32'(sram_addr_b), 32'd9);
      end else begin
        eng_wren_a = 1'b0;
        eng_rden_b = 1'b0;
      end
      tick();
      if (ovr && k == 2) chk("overrun_set", 32'(overrun), 32'd1);
    end
    eng_wren_a = 1'b0;
    eng_rden_b = 1'b0;
    spi_valid = 1'b0;
    stream_ack = 1'b0;
    mcu_tx_rdy = 1'b0;
    for (int i = 0; i < N; i++) rd_q.push_back('{addr: 16'(i), data: ref_mem[i]});
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
  endtask

  task automatic do_stream(input bit hold_test, input int stop_at);
    int cyc;
    cyc = 0;
    if (hold_test) begin
      stream_ack = 1'b0;
      while (!mcu_rx_rdy && cyc < 20) begin
        tick();
        cyc++;
      end
      for (int k = 0; k < 10; k++) begin
        chk("hold_rdy", 32'(mcu_rx_rdy), 32'd1);
        if (rd_q.size() > 0) chk("hold_data", 32'(stream_data), 32'(rd_q[0].data));
        tick();
      end
    end
    cyc = 0;
    while (!frame_finished && cyc < 400) begin
      if (stop_at >= 0 && acc_cnt == stop_at && mcu_rx_rdy) begin
        stream_ack = 1'b0;
        break;
      end
      stream_ack = 1'($urandom_range(0, 1));
      eng_done   = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    stream_ack = 1'b0;
    eng_done = 1'b0;
    if (stop_at < 0 && !frame_finished) fail("stream_timeout", 32'(acc_cnt), 32'(N));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rdy"}, 32'(mcu_rx_rdy), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_eng_start"}, 32'(eng_start), 32'd0);
    chk({tag, "_wren"}, 32'(sram_wren_a), 32'd0);
    chk({tag, "_rden"}, 32'(sram_rden_b), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_stream_data"}, 32'(stream_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk_all_zero("reset");
    #10 rst = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_after_reset", 32'(busy), 32'd0);
    end

    // Engine requests outside DITHER must not reach the SRAM
    eng_wren_a = 1'b1; eng_addr_a = 16'd5; eng_data_a = 8'hFF; eng_rden_b = 1'b1;
    #1;
    chk("idle_eng_wren", 32'(sram_wren_a), 32'd0);
    chk("idle_eng_rden", 32'(sram_rden_b), 32'd0);
    tick();
    eng_wren_a = 1'b0; eng_rden_b = 1'b0;

    // Frame 1: sequential bytes, no gaps, plain dither, held ack
    do_load(1'b0, 1'b1);
    do_dither(1'b0, 1'b0);
    do_stream(1'b1, -1);
    repeat (2) tick();

    // Frame 2: gaps, random data, engine write and an overrun during DITHER
    do_load(1'b1, 1'b0);
    do_dither(1'b1, 1'b1);
    do_stream(1'b0, -1);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    repeat (2) tick();

    // Frame 3: interrupted by reset in STREAM_HOLD at pixel 7
    do_load(1'b1, 1'b0);
    do_dither(1'b0, 1'b0);
    do_stream(1'b0, 7);
    chk("pre_reset_rdy", 32'(mcu_rx_rdy), 32'd1);
    chk("pre_reset_pixel", 32'(acc_cnt), 32'd7);
    #1 rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    rd_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    stream_ack = 1'b1;
    eng_done = 1'b1;
    repeat (4) begin
      tick();
      chk("idle_hold_after_reset", 32'(busy), 32'd0);
    end
    stream_ack = 1'b0;
    eng_done = 1'b0;

    // Frame 4: restarts from address 0
    do_load(1'b1, 1'b0);
    do_dither(1'b0, 1'b0);
    do_stream(1'b0, -1);
    repeat (3) tick();

    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
